// File: rtl/compare_pkg.sv
// compare_pkg: shared result encoding, FSM states and default operand width for seq_compare_ctrl
package compare_pkg;
  localparam int NBYTES_DEF = 4;
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
endpackage

// File: rtl/seq_compare_ctrl_if.sv
// seq_compare_ctrl_if: start/done request bus; master = requester, slave = sequencer
//   iStart/iData_a/iData_b flow master->slave, oBusy/oDone/oData/oSteps flow slave->master
interface seq_compare_ctrl_if #(parameter int NBYTES = compare_pkg::NBYTES_DEF);
  localparam int CW = $clog2(NBYTES) + 1;
  logic iStart;
  logic [8*NBYTES-1:0] iData_a;
  logic [8*NBYTES-1:0] iData_b;
  logic oBusy;
  logic oDone;
  logic [2:0] oData;
  logic [CW-1:0] oSteps;
  modport master(output iStart, iData_a, iData_b, input oBusy, oDone, oData, oSteps);
  modport slave(input iStart, iData_a, iData_b, output oBusy, oDone, oData, oSteps);
endinterface

// File: rtl/byte_compare8.sv
// byte_compare8: combinational unsigned 8-bit compare; ports a, b in; gt, eq, lt out (exactly one high)
module byte_compare8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;
endmodule

// File: rtl/seq_compare_ctrl.sv
// seq_compare_ctrl: MSB-first byte-serial unsigned compare with early exit
//   iClk/iRst: clock, sync active-high reset; bus: slave side of seq_compare_ctrl_if
module seq_compare_ctrl
  import compare_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  localparam int CW = $clog2(NBYTES) + 1
) (
  input logic iClk,
  input logic iRst,
  seq_compare_ctrl_if.slave bus
);
  localparam int IW = $clog2(NBYTES);
  state_t state_q, state_d;
  logic [8*NBYTES-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d, steps_q, steps_d;
  logic [2:0] res_q, res_d;
  logic gt, eq, lt, start_ok, fin, in_cmp;
  // one shared comparator, muxed onto the current byte
  byte_compare8 u_cmp (
    .a  (a_q[{idx_q, 3'b000} +: 8]),
    .b  (b_q[{idx_q, 3'b000} +: 8]),
    .gt (gt),
    .eq (eq),
    .lt (lt)
  );
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      steps_q <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      res_q   <= res_d;
    end
  end
  always_comb begin
    in_cmp   = state_q == CMP;
    start_ok = bus.iStart && !in_cmp;
    fin      = in_cmp && (!eq || idx_q == '0);
    state_d  = start_ok ? CMP : in_cmp ? (fin ? DONE : CMP) : IDLE;
  end
  always_comb begin
    a_d     = start_ok ? bus.iData_a : a_q;
    b_d     = start_ok ? bus.iData_b : b_q;
    idx_d   = start_ok ? IW'(NBYTES - 1) : (in_cmp && !fin) ? idx_q - IW'(1) : idx_q;
    cnt_d   = start_ok ? '0 : in_cmp ? cnt_q + CW'(1) : cnt_q;
    steps_d = fin ? cnt_q + CW'(1) : steps_q;
    res_d   = fin ? (gt ? RES_GT : lt ? RES_LT : RES_EQ) : res_q;
  end
  always_comb begin
    bus.oBusy  = state_q == CMP;
    bus.oDone  = state_q == DONE;
    bus.oData  = res_q;
    bus.oSteps = steps_q;
  end
endmodule

// File: tb/tb_seq_compare_ctrl.sv
// tb_seq_compare_ctrl: directed and random checks of seq_compare_ctrl against a magnitude-compare model
module tb_seq_compare_ctrl;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  seq_compare_ctrl_if #(.NBYTES(NB)) bus ();
  seq_compare_ctrl #(.NBYTES(NB)) dut (.iClk(clk), .iRst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int ref_k(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    for (int i = 31; i >= 0; i--)
      if (x[i]) return NB - i / 8;
    return NB;
  endfunction
  function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b);
    return a > b ? 3'b100 : a < b ? 3'b001 : 3'b010;
  endfunction
  function automatic logic [31:0] near(input logic [31:0] a);
    int sh;
    logic [31:0] m;
    if ($urandom_range(0, 5) == 0) return a;
    sh = $urandom_range(0, 31);
    m = (32'h2 << sh) - 32'h1;
    return (a & ~m) | ($urandom & m);
  endfunction
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
    int k, busy_n;
    bit seen;
    k = ref_k(a, b);
    busy_n = 0;
    seen = 0;
    @(negedge clk);
    check("idle_no_done", bus.oDone, 0);
    bus.iStart = 1'b1;
    bus.iData_a = a;
    bus.iData_b = b;
    for (int c = 1; c <= NB + 3 && !seen; c++) begin
      @(negedge clk);
      bus.iStart = poke && c == 1;
      if (poke && c == 1) begin
        bus.iData_a = ~a;
        bus.iData_b = a;
      end
      if (bus.oBusy && bus.oDone) check("busy_done_overlap", 1, 0);
      busy_n += int'(bus.oBusy);
      if (bus.oDone) begin
        seen = 1;
        check("latency", c, k + 1);
        check("data", bus.oData, ref_res(a, b));
        check("steps", bus.oSteps, k);
        check("busy_cycles", busy_n, k);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask
  task automatic run_b2b(input int n);
    logic [31:0] pa[$], pb[$];
    logic [31:0] x, y;
    int k;
    for (int i = 0; i < n; i++) begin
      x = $urandom;
      y = near(x);
      pa.push_back(i % 2 ? y : x);
      pb.push_back(i % 2 ? x : y);
    end
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iData_a = pa[0];
    bus.iData_b = pb[0];
    for (int i = 0; i < n; i++) begin
      k = ref_k(pa[i], pb[i]);
      for (int c = 1; c <= k; c++) begin
        @(negedge clk);
        check("b2b_busy", bus.oBusy, 1);
        check("b2b_no_done", bus.oDone, 0);
      end
      @(negedge clk);
      check("b2b_done", bus.oDone, 1);
      check("b2b_not_busy", bus.oBusy, 0);
      check("b2b_data", bus.oData, ref_res(pa[i], pb[i]));
      check("b2b_steps", bus.oSteps, k);
      if (i < n - 1) begin
        bus.iData_a = pa[i+1];
        bus.iData_b = pb[i+1];
      end else bus.iStart = 1'b0;
    end
  endtask
  initial begin
    logic [31:0] a;
    bus.iStart = 1'b0;
    bus.iData_a = '0;
    bus.iData_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", bus.oData, 0);
    check("rst_busy", bus.oBusy, 0);
    check("rst_done", bus.oDone, 0);
    check("rst_steps", bus.oSteps, 0);
    rst = 1'b0;
    run_op(32'h12345678, 32'h12345679, 0);
    run_op(32'hFF000000, 32'h01FFFFFF, 0);
    run_op(32'hA5A5A5A5, 32'hA5A5A5A5, 0);
    run_op(32'h00000000, 32'h00000000, 0);
    run_op(32'h1234AA00, 32'h1234AB00, 1);
    run_b2b(8);
    @(negedge clk);
    check("b2b_pulse_end", bus.oDone, 0);
    bus.iStart = 1'b1;
    bus.iData_a = 32'hDEADBEEF;
    bus.iData_b = 32'hDEADBEEF;
    @(negedge clk);
    bus.iStart = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.oBusy, 0);
    check("abort_done", bus.oDone, 0);
    check("abort_data", bus.oData, 0);
    check("abort_steps", bus.oSteps, 0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", bus.oDone, 0);
    end
    run_op(32'h00010000, 32'h00000001, 0);
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      run_op(a, near(a), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_compare_ctrl.md
# seq_compare_ctrl

Multi-cycle unsigned magnitude comparator sequencer. It compares two NBYTES-byte operands using a single shared 8-bit compare unit, one byte per clock, most-significant byte first. It terminates early on the first unequal byte. It sits between a requester using a start/done handshake and the byte comparator datapath, and returns the result in the team's 3-bit {gt,eq,lt} one-hot encoding.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 2–16.
- CW, default $clog2(NBYTES)+1: width of the step counter output (derived, not overridden).

- iClk  in  1: clock; all state updates on the rising edge.
- iRst  in  1: synchronous, active-high reset.
- iStart  in  1: request pulse or level; sampled only when the block is not busy.
- iData_a  in  8*NBYTES: operand A, unsigned; latched on an accepted start.
- iData_b  in  8*NBYTES: operand B, unsigned; latched on an accepted start.
- oBusy  out  1: high while a comparison is in progress (CMP state).
- oDone  out  1: one-cycle pulse when oData becomes valid.
- oData  out  3: result, {gt,eq,lt}: 3'b100 means A>B, 3'b010 means A==B, 3'b001 means A<B; 3'b000 means no result yet.
- oSteps  out  CW: number of byte comparisons used by the last completed operation (1..NBYTES).

## Operation
- States:
  - IDLE: waiting for a request.
  - CMP: one byte compared per cycle.
  - DONE: one cycle; drives the oDone pulse.
- IDLE or DONE, with iStart=1:
  - latch iData_a and iData_b into internal registers;
  - set byte index idx = NBYTES-1 and clear the step count;
  - go to CMP.
  - iStart in DONE is accepted as a back-to-back request; oDone still pulses that cycle.
- CMP, each cycle:
  - feed byte idx of the latched A and B to the byte comparator;
  - increment the step count.
  - If the bytes differ: register gt/lt into oData, set oSteps, go to DONE.
  - If the bytes are equal and idx==0: set oData=3'b010 and oSteps=NBYTES, go to DONE.
  - Otherwise decrement idx and stay in CMP.
- DONE: oDone=1. Go to IDLE, or back to CMP if iStart=1.
- iStart while in CMP is ignored; there is no queueing. The operand inputs are don't-care while busy.
- oData and oSteps hold their values until the next completion; they are not cleared when a new operation starts.
- Only unsigned comparison is supported. There is no sign handling.
- Reset (iRst=1 at any clock edge, including mid-CMP): state becomes IDLE, oBusy=0, oDone=0, oData=3'b000, oSteps=0, idx=0, and the operand registers are cleared. An aborted operation produces no oDone.

## Timing
- Start accepted at edge T0. CMP occupies the cycles after T0, T1, … T(k−1), where k is the number of bytes examined. oDone and the valid oData/oSteps are visible in the cycle after edge Tk.
- Latency from the start edge to the oDone cycle is k+1 cycles:
  - minimum 2 (MSB differs);
  - maximum NBYTES+1 (equal operands, or only the LSB differs).
- oBusy is high exactly k cycles per operation. oBusy and oDone are never high together.
- Back-to-back throughput: a new operation can start in the DONE cycle, so the repeat period is k+1 cycles.
- The byte comparator path is purely combinational from registered operands and idx. Result registers are updated at the same edge as the transition to DONE.

## Structure
- Shared package `compare_pkg` holds:
  - result constants RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001, RES_NONE=3'b000;
  - the state encoding (IDLE, CMP, DONE);
  - the NBYTES default.
- Sub-module `byte_compare8`: a combinational 8-bit unsigned compare with outputs gt, eq, lt, exactly one high. It is instantiated once and shared across all byte positions by the idx mux.
- The top level contains the FSM, operand registers, idx down-counter, step counter, and result registers.

## Test plan
All scenarios use NBYTES=4.
- Reset: hold iRst for 2 cycles → oData=000, oBusy=0, oDone=0, oSteps=0; then iStart with A=0x12345678, B=0x12345679 → oData=001, oSteps=4, oDone exactly 5 cycles after the start edge.
- MSB decides: A=0xFF000000, B=0x01FFFFFF → oData=100, oSteps=1, oBusy high 1 cycle, oDone at start+2.
- Equal operands: A=B=0xA5A5A5A5 → oData=010, oSteps=4; also A=B=0 → oData=010, oSteps=4.
- Mid-byte decision plus busy protection: A=0x1234AA00, B=0x1234AB00 → oData=001, oSteps=3; an iStart pulse with different operands during CMP is ignored, and the result is unchanged.
- Back-to-back: hold iStart high with alternating operand pairs → a new operation starts in every DONE cycle; each oDone is a single-cycle pulse; results match the golden model.
- Reset mid-operation: assert iRst during the second CMP cycle → IDLE next cycle, no oDone, oData=000; a subsequent request completes normally. Finish with 10k random operand pairs against a `>` / `<` golden model, checking oData, oSteps, and the latency formula.
